// File: rtl/acc_resp_unit.sv
// Reference accelerator on the offload Q/P channel pair: single-cycle ADD/XOR and
// iterative shift-add MUL/MAC, one outstanding request, response held until taken.
module acc_resp_unit #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter logic [6:0]  Opcode    = 7'b0001011
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          q_data_op,
    input  logic [DataWidth-1:0] q_data_arga,
    input  logic [DataWidth-1:0] q_data_argb,
    input  logic [DataWidth-1:0] q_data_argc,
    input  logic [IdWidth-1:0]   q_id,
    input  logic                 q_valid,
    output logic                 q_ready,
    output logic [DataWidth-1:0] p_data,
    output logic [IdWidth-1:0]   p_id,
    output logic                 p_error,
    output logic                 p_valid,
    input  logic                 p_ready
);

    localparam int unsigned CntWidth = $clog2(DataWidth + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   mcand_q, mcand_d;
    logic [DataWidth-1:0]   mplier_q, mplier_d;
    logic [DataWidth-1:0]   acc_q, acc_d;
    logic [DataWidth-1:0]   argc_q, argc_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   is_mac_q, is_mac_d;
    logic [DataWidth-1:0]   p_data_q, p_data_d;
    logic [IdWidth-1:0]     p_id_q, p_id_d;
    logic                   p_error_q, p_error_d;

    logic [2:0]             funct3;
    logic [DataWidth-1:0]   acc_sum;
    logic [CntWidth-1:0]    cnt_dec;
    logic                   unused_op;

    // Register/immediate fields are irrelevant to this unit.
    assign unused_op = ^{q_data_op[31:15], q_data_op[11:7]};
    assign funct3    = q_data_op[14:12];
    assign acc_sum   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign cnt_dec   = cnt_q - CntWidth'(1);

    assign q_ready = (state_q == StIdle);
    assign p_valid = (state_q == StResp);
    assign p_data  = p_data_q;
    assign p_id    = p_id_q;
    assign p_error = p_error_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        argc_d    = argc_q;
        cnt_d     = cnt_q;
        is_mac_d  = is_mac_q;
        p_data_d  = p_data_q;
        p_id_d    = p_id_q;
        p_error_d = p_error_q;

        unique case (state_q)
            StIdle: begin
                if (q_valid) begin
                    p_id_d    = q_id;
                    mcand_d   = q_data_arga;
                    mplier_d  = q_data_argb;
                    argc_d    = q_data_argc;
                    p_error_d = 1'b0;
                    state_d   = StResp;
                    if (q_data_op[6:0] == Opcode) begin
                        case (funct3)
                            3'b000: p_data_d = q_data_arga + q_data_argb;
                            3'b011: p_data_d = q_data_arga ^ q_data_argb;
                            3'b001, 3'b010: begin
                                acc_d    = '0;
                                cnt_d    = CntWidth'(DataWidth);
                                is_mac_d = (funct3 == 3'b010);
                                state_d  = StBusy;
                            end
                            default: begin
                                p_data_d  = '0;
                                p_error_d = 1'b1;
                            end
                        endcase
                    end else begin
                        p_data_d  = '0;
                        p_error_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_dec;
                // The final iteration and the result write share one edge.
                if (cnt_dec == '0) begin
                    p_data_d = is_mac_q ? acc_sum + argc_q : acc_sum;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (p_ready) begin
                    p_error_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            argc_q    <= '0;
            cnt_q     <= '0;
            is_mac_q  <= 1'b0;
            p_data_q  <= '0;
            p_id_q    <= '0;
            p_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            argc_q    <= argc_d;
            cnt_q     <= cnt_d;
            is_mac_q  <= is_mac_d;
            p_data_q  <= p_data_d;
            p_id_q    <= p_id_d;
            p_error_q <= p_error_d;
        end
    end

endmodule

// File: tb/tb_acc_resp_unit.sv
// Self-checking bench for acc_resp_unit: directed vector table, corner-case
// sequences and randomized requests against an arithmetic reference model.
module tb_acc_resp_unit;

    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   q_data_op = '0;
    logic [DW-1:0] q_data_arga = '0, q_data_argb = '0, q_data_argc = '0;
    logic [IW-1:0] q_id = '0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [DW-1:0] p_data;
    logic [IW-1:0] p_id;
    logic          p_error;
    logic          p_valid;
    logic          p_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    acc_resp_unit #(.DataWidth(DW), .IdWidth(IW), .Opcode(7'b0001011)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .q_data_op  (q_data_op),
        .q_data_arga(q_data_arga),
        .q_data_argb(q_data_argb),
        .q_data_argc(q_data_argc),
        .q_id       (q_id),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .p_data     (p_data),
        .p_id       (p_id),
        .p_error    (p_error),
        .p_valid    (p_valid),
        .p_ready    (p_ready)
    );

    typedef struct {
        logic [31:0]   op;
        logic [DW-1:0] a, b, c;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic          e;
        int            lat;
    } vec_t;

    localparam logic [31:0] OpAdd = 32'h0000_000B;
    localparam logic [31:0] OpMul = 32'h0000_100B;
    localparam logic [31:0] OpMac = 32'h0000_200B;
    localparam logic [31:0] OpXor = 32'h0000_300B;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: instruction semantics via plain arithmetic.
    function automatic void model(input logic [31:0] op, input logic [DW-1:0] a, b, c,
                                  output logic [DW-1:0] d, output logic e, output int lat);
        logic [2*DW-1:0] prod;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        d = '0;
        e = 1'b1;
        lat = 0;
        if (op[6:0] == 7'b0001011) begin
            case (op[14:12])
                3'd0: begin d = a + b; e = 1'b0; end
                3'd3: begin d = a ^ b; e = 1'b0; end
                3'd1: begin d = prod[DW-1:0]; e = 1'b0; lat = DW; end
                3'd2: begin d = prod[DW-1:0] + c; e = 1'b0; lat = DW; end
                default: ;
            endcase
        end
    endfunction

    // Excludes q_ready and p_valid being high together.
    always @(negedge clk) begin
        if (rst_n && q_ready && p_valid) begin
            miscompares++;
            $display("FAIL ready_valid_excl: got q_ready=1 p_valid=1, expected not both");
        end
    end

    task automatic send(input logic [31:0] op, input logic [DW-1:0] a, b, c,
                        input logic [IW-1:0] id);
        int n = 0;
        @(negedge clk);
        while (!q_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!q_ready) begin
            chk("q_ready_timeout", 64'(q_ready), 64'd1);
            return;
        end
        q_data_op = op;
        q_data_arga = a;
        q_data_argb = b;
        q_data_argc = c;
        q_id = id;
        q_valid = 1'b1;
        @(posedge clk);
        #1 q_valid = 1'b0;
    endtask

    // lat = number of edges after the Q handshake edge before p_valid shows.
    task automatic recv(input int stall, output logic [DW-1:0] d, output logic [IW-1:0] id,
                        output logic e, output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        d = '0;
        id = '0;
        e = 1'b0;
        @(negedge clk);
        while (!p_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!p_valid) begin
            chk("p_valid_timeout", 64'(p_valid), 64'd1);
            return;
        end
        d = p_data;
        id = p_id;
        e = p_error;
        repeat (stall) begin
            @(negedge clk);
            chk("stall_stable", {p_valid, q_ready, p_error, p_id, p_data},
                {1'b1, 1'b0, e, id, d});
        end
        p_ready = 1'b1;
        @(posedge clk);
        #1 p_ready = 1'b0;
        ok = 1'b1;
    endtask

    vec_t tbl[10];

    initial begin
        logic [DW-1:0] d, ed;
        logic [IW-1:0] id;
        logic          e, ee;
        int            lat, elat, seen;
        bit            ok;

        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d, ed, a, b, c;
        logic [IW-1:0] id, rid;
        logic          e, ee;
        int            lat, elat, seen, kind, stall;
        bit            ok;
        logic [31:0]   op;

        tbl[0] = '{OpAdd, 32'd5, 32'd7, 32'd0, 4'd3, 32'd12, 1'b0, 0};
        tbl[1] = '{OpAdd, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd1, 32'd1, 1'b0, 0};
        tbl[2] = '{OpXor, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 4'd2, 32'h0FF0_0FF0, 1'b0, 0};
        tbl[3] = '{OpMul, 32'h0001_0001, 32'h0001_0003, 32'd0, 4'd9, 32'h0004_0003, 1'b0, 32};
        tbl[4] = '{OpMac, 32'd3, 32'd4, 32'hFFFF_FFFF, 4'd4, 32'd11, 1'b0, 32};
        tbl[5] = '{32'h0000_0033, 32'd8, 32'd9, 32'd0, 4'd5, 32'd0, 1'b1, 0};
        tbl[6] = '{32'h0000_700B, 32'd8, 32'd9, 32'd0, 4'd6, 32'd0, 1'b1, 0};
        tbl[7] = '{OpAdd, 32'd100, 32'd23, 32'd0, 4'd7, 32'd123, 1'b0, 0};
        tbl[8] = '{32'h0000_400B, 32'd1, 32'd1, 32'd0, 4'd15, 32'd0, 1'b1, 0};
        tbl[9] = '{OpMac, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 4'd8, 32'd6, 1'b0, 32};

        // Reset with a pending request: nothing captured, outputs at reset values.
        rst_n = 1'b0;
        p_ready = 1'b1;
        q_valid = 1'b1;
        q_data_op = OpAdd;
        q_data_arga = 32'd55;
        q_data_argb = 32'd66;
        q_id = 4'hA;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {q_ready, p_valid, p_error, p_id, p_data},
            {1'b1, 1'b0, 1'b0, 4'd0, 32'd0});
        q_valid = 1'b0;
        p_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {q_ready, p_valid}, {1'b1, 1'b0});

        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].id);
            recv(0, d, id, e, lat, ok);
            if (ok) begin
                chk($sformatf("vec%0d_data", i), d, tbl[i].d);
                chk($sformatf("vec%0d_id", i), id, tbl[i].id);
                chk($sformatf("vec%0d_err", i), e, tbl[i].e);
                chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            end
        end

        // Backpressure with a new request waiting on the Q side.
        send(OpAdd, 32'd1, 32'd2, 32'd0, 4'd6);
        @(negedge clk);
        chk("bp_first", {p_valid, p_data, p_id}, {1'b1, 32'd3, 4'd6});
        q_data_op = OpXor;
        q_data_arga = 32'h0000_AAAA;
        q_data_argb = 32'h0000_5555;
        q_id = 4'd5;
        q_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {p_valid, q_ready, p_error, p_data, p_id},
                {1'b1, 1'b0, 1'b0, 32'd3, 4'd6});
        end
        p_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_release_idle", {q_ready, p_valid}, {1'b1, 1'b0});
        p_ready = 1'b0;
        @(posedge clk);
        #1 q_valid = 1'b0;
        chk("bp_next_accepted", {q_ready, p_valid, p_data, p_id}, {1'b0, 1'b1, 32'h0000_FFFF, 4'd5});
        p_ready = 1'b1;
        @(posedge clk);
        #1 p_ready = 1'b0;

        // Reset in the middle of a multiply drops it.
        send(OpMul, 32'd1234, 32'd5678, 32'd0, 4'd12);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midbusy_rst", {q_ready, p_valid, p_error, p_id, p_data},
               {1'b1, 1'b0, 1'b0, 4'd0, 32'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (p_valid) seen++;
        end
        chk("midbusy_no_resp", seen, 0);
        send(OpAdd, 32'd40, 32'd2, 32'd0, 4'd11);
        recv(0, d, id, e, lat, ok);
        if (ok) chk("after_rst_add", {lat, e, id, d}, {32'd0, 1'b0, 4'd11, 32'd42});

        // Randomized requests against the model.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            op = $urandom;
            case (kind)
                0: op[14:12] = 3'd0;
                1: op[14:12] = 3'd1;
                2: op[14:12] = 3'd2;
                3: op[14:12] = 3'd3;
                4: op[14:12] = 3'($urandom_range(4, 7));
                default: ;
            endcase
            if (kind != 5) op[6:0] = 7'b0001011;
            else if (op[6:0] == 7'b0001011) op[6:0] = 7'b0110011;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            c = $urandom;
            rid = IW'($urandom);
            stall = $urandom_range(0, 3);
            model(op, a, b, c, ed, ee, elat);
            send(op, a, b, c, rid);
            recv(stall, d, id, e, lat, ok);
            if (ok) begin
                chk($sformatf("rnd%0d_data", n), d, ed);
                chk($sformatf("rnd%0d_id", n), id, rid);
                chk($sformatf("rnd%0d_err", n), e, ee);
                chk($sformatf("rnd%0d_lat", n), lat, elat);
            end
        end

        @(negedge clk);
        chk("final_idle", {q_ready, p_valid, p_error}, {1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
